// File: rtl/cfg_chain_loader.sv
// Configuration chain loader: accepts host words over valid/ready and serialises
// them MSB-first onto two parallel config chains (bank A, bank B).
module cfg_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 30,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              abort,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WORD_W-1:0] wr_data,
  output logic              cfg_en,
  output logic              cfg_dataA,
  output logic              cfg_dataB,
  output logic              busy,
  output logic              done
);

  localparam int HALF  = WORD_W / 2;
  localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] LEN      = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_WORD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  logic [HALF-1:0]  sh_a;
  logic [HALF-1:0]  sh_b;
  logic [HALF-1:0]  sh_a_shl;
  logic [HALF-1:0]  sh_b_shl;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] rem_m1;
  logic [IDX_W-1:0] bit_idx;
  logic             accept;

  assign accept   = wr_valid & wr_ready;
  assign sh_a_shl = sh_a << 1;
  assign sh_b_shl = sh_b << 1;
  assign rem_m1   = remaining - CNT_ONE;

  // wr_ready is registered, so each branch precomputes whether the *next* cycle
  // will be able to take a word (WAIT_WORD, or the last bit of a non-final word).
  // NOTE: all state lives in this one clocked block and uses non-blocking
  // assignments; the asynchronous reset clears the shift registers too, so no
  // stale word can leak onto the chains after a mid-load reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      sh_a      <= '0;
      sh_b      <= '0;
      remaining <= '0;
      bit_idx   <= '0;
      wr_ready  <= 1'b0;
      cfg_en    <= 1'b0;
      cfg_dataA <= 1'b0;
      cfg_dataB <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        state     <= S_IDLE;
        wr_ready  <= 1'b0;
        cfg_en    <= 1'b0;
        cfg_dataA <= 1'b0;
        cfg_dataB <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start && !abort) begin
              state     <= S_WAIT_WORD;
              remaining <= LEN;
              wr_ready  <= 1'b1;
              busy      <= 1'b1;
            end
          end

          S_WAIT_WORD: begin
            if (accept) begin
              state     <= S_SHIFT;
              sh_a      <= wr_data[HALF-1:0];
              sh_b      <= wr_data[WORD_W-1:HALF];
              bit_idx   <= IDX_LAST;
              cfg_en    <= 1'b1;
              cfg_dataA <= wr_data[HALF-1];
              cfg_dataB <= wr_data[WORD_W-1];
              wr_ready  <= (IDX_LAST == '0) && (remaining != CNT_ONE);
            end
          end

          S_SHIFT: begin
            remaining <= rem_m1;
            if (remaining == CNT_ONE) begin
              state     <= S_DONE;
              wr_ready  <= 1'b0;
              cfg_en    <= 1'b0;
              cfg_dataA <= 1'b0;
              cfg_dataB <= 1'b0;
              done      <= 1'b1;
            end else if (bit_idx == '0) begin
              if (accept) begin
                // Back-to-back word: reload without a bubble, cfg_en stays high.
                sh_a      <= wr_data[HALF-1:0];
                sh_b      <= wr_data[WORD_W-1:HALF];
                bit_idx   <= IDX_LAST;
                cfg_dataA <= wr_data[HALF-1];
                cfg_dataB <= wr_data[WORD_W-1];
                wr_ready  <= (IDX_LAST == '0) && (rem_m1 != CNT_ONE);
              end else begin
                state     <= S_WAIT_WORD;
                wr_ready  <= 1'b1;
                cfg_en    <= 1'b0;
                cfg_dataA <= 1'b0;
                cfg_dataB <= 1'b0;
              end
            end else begin
              sh_a      <= sh_a_shl;
              sh_b      <= sh_b_shl;
              bit_idx   <= bit_idx - IDX_ONE;
              cfg_dataA <= sh_a_shl[HALF-1];
              cfg_dataB <= sh_b_shl[HALF-1];
              wr_ready  <= (bit_idx == IDX_ONE) && (rem_m1 != CNT_ONE);
            end
          end

          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: a bit-stream model derived from the host
// words, a model of the downstream 30-bit chains, and literal chain images.
module tb_cfg_chain_loader;

  localparam int WORD_W    = 32;
  localparam int CHAIN_LEN = 30;
  localparam int HALF      = WORD_W / 2;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_ABORT  = 1;
  localparam int MODE_RESET  = 2;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [WORD_W-1:0] wr_data = '0;
  logic              cfg_en;
  logic              cfg_dataA;
  logic              cfg_dataB;
  logic              busy;
  logic              done;

  int n_cmp = 0;
  int n_bad = 0;

  logic exp_a[$];
  logic exp_b[$];
  logic mon_a;
  logic mon_b;

  logic [CHAIN_LEN-1:0] chain_a;
  logic [CHAIN_LEN-1:0] chain_b;

  cfg_chain_loader #(
    .WORD_W   (WORD_W),
    .CHAIN_LEN(CHAIN_LEN)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .start    (start),
    .abort    (abort),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .cfg_en   (cfg_en),
    .cfg_dataA(cfg_dataA),
    .cfg_dataB(cfg_dataB),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream chains: shift in at the LSB so the first bit ends at the MSB.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      chain_a <= '0;
      chain_b <= '0;
    end else if (cfg_en) begin
      chain_a <= {chain_a[CHAIN_LEN-2:0], cfg_dataA};
      chain_b <= {chain_b[CHAIN_LEN-2:0], cfg_dataB};
    end
  end

  // Every enabled cycle must present the next bit of the expected stream.
  always @(negedge clk) begin
    if (nrst && cfg_en) begin
      if (exp_a.size() == 0) begin
        check("unexpected_shift", cfg_en, 1'b0);
      end else begin
        mon_a = exp_a.pop_front();
        mon_b = exp_b.pop_front();
        check("cfg_dataA", cfg_dataA, mon_a);
        check("cfg_dataB", cfg_dataB, mon_b);
      end
    end
    if (nrst && done) check("done_without_en", cfg_en, 1'b0);
    if (nrst && !busy) check("ready_while_idle", wr_ready, 1'b0);
  end

  // Expected stream: the first CHAIN_LEN bits of the words' halves, MSB first.
  task automatic build_expect(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1);
    logic [WORD_W-1:0] w;
    int b;
    exp_a.delete();
    exp_b.delete();
    for (int i = 0; i < CHAIN_LEN; i++) begin
      w = (i / HALF == 0) ? w0 : w1;
      b = HALF - 1 - (i % HALF);
      exp_a.push_back(w[b]);
      exp_b.push_back(w[HALF + b]);
    end
  endtask

  task automatic run_load(input string tag, input logic [WORD_W-1:0] w0,
                          input logic [WORD_W-1:0] w1, input int gap_n,
                          input int exp_low, input int mode, input int event_at,
                          input int start_at);
    int en_cnt, done_cnt, hs_cnt, widx, gap_left;
    int first_en, last_en, done_cyc, low_inside, pend_low, stop_cyc;
    bit hs, fired, start_fired;
    en_cnt = 0; done_cnt = 0; hs_cnt = 0; widx = 0; gap_left = 0;
    first_en = -1; last_en = -1; done_cyc = -1; low_inside = 0; pend_low = 0;
    stop_cyc = -1; fired = 0; start_fired = 0;
    build_expect(w0, w1);

    @(posedge clk); #1;
    start = 1'b1;
    wr_valid = 1'b1;
    wr_data = w0;
    @(posedge clk); #1;
    start = 1'b0;

    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cfg_en) begin
        en_cnt++;
        check({tag, "_busy_in_shift"}, busy, 1'b1);
        if (first_en >= 0) low_inside += pend_low;
        else first_en = c;
        pend_low = 0;
        last_en = c;
      end else if (first_en >= 0) begin
        pend_low++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      hs = wr_valid && wr_ready;
      if (mode == MODE_ABORT && !fired && en_cnt == event_at) begin
        abort = 1'b1;
        fired = 1;
        hs = 0;
        stop_cyc = c + 8;
      end
      if (mode == MODE_RESET && !fired && en_cnt == event_at) begin
        nrst = 1'b0;
        #1;
        check({tag, "_rst_cfg_en"}, cfg_en, 1'b0);
        check({tag, "_rst_dataA"}, cfg_dataA, 1'b0);
        check({tag, "_rst_dataB"}, cfg_dataB, 1'b0);
        check({tag, "_rst_ready"}, wr_ready, 1'b0);
        check({tag, "_rst_busy"}, busy, 1'b0);
        check({tag, "_rst_done"}, done, 1'b0);
        wr_valid = 1'b0;
        #2;
        nrst = 1'b1;
        @(negedge clk);
        check({tag, "_post_rst_busy"}, busy, 1'b0);
        check({tag, "_post_rst_cfg_en"}, cfg_en, 1'b0);
        break;
      end
      if (start_at > 0 && !start_fired && en_cnt == start_at) begin
        start = 1'b1;
        start_fired = 1;
      end
      if (mode == MODE_NORMAL && done_cyc >= 0 && c >= done_cyc + 2) break;
      if (mode == MODE_ABORT && fired && c >= stop_cyc) break;

      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      if (hs) begin
        hs_cnt++;
        widx++;
        if (widx == 1 && gap_n > 0) begin
          wr_valid = 1'b0;
          wr_data = 32'h5555_AAAA;
          gap_left = gap_n;
        end else begin
          wr_data = (widx == 1) ? w1 : 32'hDEAD_BEEF;
        end
      end else if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) begin
          wr_valid = 1'b1;
          wr_data = w1;
        end
      end
    end

    wr_valid = 1'b0;
    if (mode == MODE_NORMAL) begin
      check({tag, "_en_cycles"}, en_cnt, CHAIN_LEN);
      check({tag, "_en_low_inside"}, low_inside, exp_low);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_done_after_en"}, done_cyc, last_en + 1);
      check({tag, "_handshakes"}, hs_cnt, 2);
      check({tag, "_bits_left"}, exp_a.size(), 0);
      check({tag, "_busy_end"}, busy, 1'b0);
    end else if (mode == MODE_ABORT) begin
      check({tag, "_en_cycles"}, en_cnt, event_at);
      check({tag, "_done_pulses"}, done_cnt, 0);
      check({tag, "_handshakes"}, hs_cnt, 1);
      check({tag, "_busy_end"}, busy, 1'b0);
      check({tag, "_cfg_en_end"}, cfg_en, 1'b0);
    end
    exp_a.delete();
    exp_b.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values, sampled while nrst is held low.
    #12;
    check("reset_cfg_en", cfg_en, 1'b0);
    check("reset_dataA", cfg_dataA, 1'b0);
    check("reset_dataB", cfg_dataB, 1'b0);
    check("reset_ready", wr_ready, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    nrst = 1'b1;

    // wr_valid in IDLE is not accepted.
    @(posedge clk); #1;
    wr_valid = 1'b1;
    wr_data = 32'h0BAD_F00D;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_valid_ready", wr_ready, 1'b0);
      check("idle_valid_busy", busy, 1'b0);
    end

    // abort together with start in IDLE: stay idle.
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_start_busy", busy, 1'b0);
    check("abort_start_ready", wr_ready, 1'b0);
    wr_valid = 1'b0;

    // Continuous load; the chain images are hand-derived from the two words.
    run_load("s1", 32'hA5A5_3C3C, 32'hFFFF_0001, 0, 0, MODE_NORMAL, 0, 0);
    check("s1_chainA", chain_a, 30'b0011_1100_0011_1100_0000_0000_0000_00);
    check("s1_chainB", chain_b, {16'hA5A5, 14'h3FFF});
    check("s1_chainA_out", chain_a[CHAIN_LEN-1], 1'b0);
    check("s1_chainB_out", chain_b[CHAIN_LEN-1], 1'b1);

    // Second word held back: six WAIT_WORD cycles with cfg_en low.
    run_load("s2", 32'hA5A5_3C3C, 32'hFFFF_0001, 21, 6, MODE_NORMAL, 0, 0);
    check("s2_chainA", chain_a, 30'b0011_1100_0011_1100_0000_0000_0000_00);

    // Abort after 10 bits, then a full load of different words.
    run_load("s4_abort", 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, MODE_ABORT, 10, 0);
    run_load("s4_reload", 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, MODE_NORMAL, 0, 0);
    check("s4_chainA", chain_a, {16'h5678, 14'h37BC});
    check("s4_chainB", chain_b, {16'h1234, 14'h26AF});

    // Reset after 12 bits, then a normal load.
    run_load("s5_reset", 32'hA5A5_3C3C, 32'hFFFF_0001, 0, 0, MODE_RESET, 12, 0);
    check("s5_chain_cleared", chain_a, 30'b0);
    run_load("s5_reload", 32'hA5A5_3C3C, 32'hFFFF_0001, 0, 0, MODE_NORMAL, 0, 0);
    check("s5_chainA", chain_a, 30'b0011_1100_0011_1100_0000_0000_0000_00);

    // start pulsed mid-shift is ignored.
    run_load("s6", 32'h0F0F_F0F0, 32'h8000_7FFF, 0, 0, MODE_NORMAL, 0, 5);
    check("s6_chainA", chain_a, {16'hF0F0, 14'h1FFF});
    check("s6_chainB", chain_b, {16'h0F0F, 14'h2000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Upstream stage of the fabric configuration chains. Accepts configuration words from the host/bitstream source over a valid/ready handshake.
- Serialises each word onto two parallel chains (bank A, bank B), driving the chain enable and serial data inputs of the first connection box / switch box in each chain.
- Shifts exactly CHAIN_LEN bits per bank per load, then pulses done.

Parameters:
- WORD_W, 32, host word width; must be even. HALF = WORD_W/2 bits per bank per word.
- CHAIN_LEN, 30, total bits per bank chain (e.g. one conbox with WIDTH=32 and 5 muxes = 6*5). Must be ≥1.
- CNT_W, $clog2(CHAIN_LEN+1), width of the remaining-bit counter.

Ports:
- clk, input, 1, fabric config clock.
- nrst, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse that begins a load; honoured only in IDLE.
- abort, input, 1, cancels an in-progress load.
- wr_valid, input, 1, host word valid.
- wr_ready, output, 1, loader can accept a word this cycle.
- wr_data, input, WORD_W, [HALF-1:0] = bank A bits, [WORD_W-1:HALF] = bank B bits; MSB of each half is shifted first.
- cfg_en, output, 1, chain shift enable (drives en of every chain element).
- cfg_dataA, output, 1, serial data into chain A (config_data_inA of first element).
- cfg_dataB, output, 1, serial data into chain B.
- busy, output, 1, high whenever state ≠ IDLE.
- done, output, 1, one-cycle pulse when load completes.

Behaviour:
- Reset is asynchronous and active-low on nrst; one clock, clk.
- Reset values: state IDLE; cfg_en, cfg_dataA, cfg_dataB, wr_ready, busy, done all 0; counters 0.
- cfg_en, cfg_dataA and cfg_dataB are registered. The chain captures the values they hold at each posedge.
- States:
  - IDLE: start → WAIT_WORD, remaining ← CHAIN_LEN. Otherwise hold.
  - WAIT_WORD: wr_ready=1, cfg_en=0. On wr_valid&wr_ready:
    - latch the word into two HALF-bit shift registers, bit_idx ← HALF-1.
    - set next-cycle cfg_en=1, cfg_dataA=wr_data[HALF-1], cfg_dataB=wr_data[WORD_W-1].
    - go to SHIFT.
  - SHIFT: each cycle one bit per bank is presented, remaining decrements.
    - When remaining==1 (final bit presented): next state DONE; wr_ready=0 for this cycle.
    - Else if bit_idx==0 (last bit of word): wr_ready=1 the same cycle.
      - If the handshake occurs, load the new word with no bubble; cfg_en stays high.
      - Else go to WAIT_WORD; cfg_en drops to 0 next cycle.
    - Else: shift, bit_idx decrements.
  - DONE: cfg_en=0, done=1 for exactly one cycle, then IDLE.
- Word usage: a load consumes ceil(CHAIN_LEN/HALF) words. Unused low bits of the final word are discarded.
- With uninterrupted valid, cfg_en is high for exactly CHAIN_LEN consecutive cycles.
- Bit ordering: the first bit shifted ends at the chain MSB, so word0[HALF-1] lands in the last chain bit of bank A.
- start while busy: ignored.
- wr_valid in IDLE or DONE: wr_ready=0, word not consumed.
- abort (any state ≠ IDLE): next cycle IDLE, cfg_en=0, no done pulse. Chain contents are left partial; the host must reload.
- abort together with start in IDLE: abort wins; stay IDLE.
- Reset mid-load: immediate return to the reset values above; chain elements reset on the same nrst.
- wr_data is sampled only on the handshake edge. Changes while wr_ready=0 have no effect.

Test Plan:
1. Reset then start with WORD_W=32, CHAIN_LEN=30; words 0xA5A5_3C3C then 0xFFFF_0001 held valid continuously → cfg_en high 30 consecutive cycles starting the cycle after word0 accept, no bubble at the word boundary. cfgA sequence is bits 15..0 of 0x3C3C then bits 15..2 of 0x0001. done pulses once, one cycle after cfg_en falls. Exactly 2 handshakes.
2. Same load with wr_valid withheld 5 cycles after word0 → cfg_en low for 6 cycles (gap of WAIT_WORD), resumes on accept; total cfg_en-high cycles still 30.
3. Integration with a 30-bit A/B chain: after scenario 1, chain A register reads 30'b0011_1100_0011_1100_0000_0000_0000_00. MSB = first bit shifted; config_data_outA then equals the first bit shifted.
4. abort asserted after 10 shifted bits → cfg_en 0 next cycle, busy 0, no done, remaining words not requested; a subsequent start performs a full 30-bit load.
5. nrst pulled low after 12 bits → all outputs 0 asynchronously; after release, start produces a normal load.
6. start pulsed during SHIFT and wr_valid asserted in IDLE → both ignored: no state change, wr_ready stays 0 in IDLE, bit count unaffected.
